// File: rtl/jt12_lin2log_pkg.sv
// Shared widths, FSM state codes and helpers for the jt12_lin2log encoder.
package jt12_lin2log_pkg;

  localparam int LIN_W  = 14;
  localparam int ATT_W  = 12;
  localparam int ROM_AW = 5;
  localparam int MAG_W  = LIN_W - 1;
  localparam int SH_W   = 4;

  localparam logic [ATT_W-1:0] ZERO_ATT_DEF = 12'hFFF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_NORM   = 2'd1;
  localparam state_t ST_LOOKUP = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // |x| in 13 bits; -8192 has no 13-bit magnitude and saturates to 8191.
  function automatic logic [MAG_W-1:0] abs_sat(input logic [LIN_W-1:0] x);
    if (!x[LIN_W-1])
      return x[MAG_W-1:0];
    else if (x[MAG_W-1:0] == '0)
      return '1;
    else
      return ~x[MAG_W-1:0] + 13'd1;
  endfunction

  function automatic logic [SH_W-1:0] lzc13(input logic [MAG_W-1:0] x);
    logic [SH_W-1:0] cnt;
    logic            found;
    cnt   = '0;
    found = 1'b0;
    for (int i = MAG_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (x[i]) found = 1'b1;
        else      cnt   = cnt + 4'd1;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/jt12_logrom.sv
// Registered 32-entry log2 mantissa table, L[k] = round(-log2((32+k)/64)*256).
// L[0]=256 does not fit 8 bits, so it is stored as 0 and the caller adds the carry.
module jt12_logrom
  import jt12_lin2log_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en_i,
  input  logic [ROM_AW-1:0] addr_i,
  output logic [7:0]        data_o
);

  logic [7:0] rom_val;
  logic [7:0] data_q;

  always_comb begin
    rom_val = 8'd0;
    case (addr_i)
      5'd0:  rom_val = 8'd0;
      5'd1:  rom_val = 8'd245;
      5'd2:  rom_val = 8'd234;
      5'd3:  rom_val = 8'd223;
      5'd4:  rom_val = 8'd212;
      5'd5:  rom_val = 8'd202;
      5'd6:  rom_val = 8'd193;
      5'd7:  rom_val = 8'd183;
      5'd8:  rom_val = 8'd174;
      5'd9:  rom_val = 8'd164;
      5'd10: rom_val = 8'd156;
      5'd11: rom_val = 8'd147;
      5'd12: rom_val = 8'd138;
      5'd13: rom_val = 8'd130;
      5'd14: rom_val = 8'd122;
      5'd15: rom_val = 8'd114;
      5'd16: rom_val = 8'd106;
      5'd17: rom_val = 8'd99;
      5'd18: rom_val = 8'd91;
      5'd19: rom_val = 8'd84;
      5'd20: rom_val = 8'd77;
      5'd21: rom_val = 8'd70;
      5'd22: rom_val = 8'd63;
      5'd23: rom_val = 8'd56;
      5'd24: rom_val = 8'd49;
      5'd25: rom_val = 8'd43;
      5'd26: rom_val = 8'd36;
      5'd27: rom_val = 8'd30;
      5'd28: rom_val = 8'd24;
      5'd29: rom_val = 8'd18;
      5'd30: rom_val = 8'd12;
      5'd31: rom_val = 8'd6;
      default: rom_val = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           data_q <= '0;
    else if (clk_en_i) data_q <= rom_val;
  end

  assign data_o = data_q;

endmodule

// File: rtl/jt12_lin2log.sv
// Linear (signed 14-bit) to log2 attenuation (4.8) encoder with valid/ready on both sides.
// Define JT12_LIN2LOG_FASTNORM_EN to normalise in a single cycle with a priority encoder.
module jt12_lin2log
  import jt12_lin2log_pkg::*;
#(
  parameter logic [11:0] ZERO_ATT = ZERO_ATT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [13:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [11:0] att,
  output logic        sign,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a word moves only on an enabled edge where valid and ready are
  // both high; att/sign hold steady for as long as dout_valid waits on dout_ready.

  state_t           state_q, state_d;
  logic [MAG_W-1:0] n_q, n_d;
  logic [SH_W-1:0]  s_q, s_d;
  logic             sign_q, sign_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic [MAG_W-1:0] mag;
  logic [7:0]       rom_q;
  logic             k_zero;

  assign mag    = abs_sat(din);
  assign k_zero = (n_q[11:7] == 5'd0);

  // ROM is addressed from the next-state mantissa so its registered output
  // lines up with n_q during LOOKUP.
  jt12_logrom u_rom (
    .clk      (clk),
    .rst      (rst),
    .clk_en_i (clk_en),
    .addr_i   (n_d[11:7]),
    .data_o   (rom_q)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    s_d     = s_q;
    sign_d  = sign_q;
    att_d   = att_q;
    case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          sign_d = din[13];
          n_d    = mag;
          s_d    = '0;
          if (mag == '0) begin
            att_d   = ZERO_ATT;
            state_d = ST_DONE;
          end
`ifdef JT12_LIN2LOG_FASTNORM_EN
          else begin
            n_d     = mag << lzc13(mag);
            s_d     = lzc13(mag);
            state_d = ST_LOOKUP;
          end
`else
          else if (mag[12]) begin
            state_d = ST_LOOKUP;
          end else begin
            state_d = ST_NORM;
          end
`endif
        end
      end
      ST_NORM: begin
        if (n_q == '0) begin
          att_d   = ZERO_ATT;
          state_d = ST_DONE;
        end else if (n_q[12]) begin
          state_d = ST_LOOKUP;
        end else begin
          // Leave on the shift that brings the leading one to bit 12.
          n_d = {n_q[11:0], 1'b0};
          s_d = s_q + 4'd1;
          if (n_q[11]) state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        att_d   = {s_q, 8'h00} + {3'b000, k_zero, rom_q};
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (dout_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      s_q     <= '0;
      sign_q  <= 1'b0;
      att_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      n_q     <= n_d;
      s_q     <= s_d;
      sign_q  <= sign_d;
      att_q   <= att_d;
    end
  end

  assign din_ready   = (state_q == ST_IDLE);
  assign dout_valid  = (state_q == ST_DONE);
  assign att         = att_q;
  assign sign        = sign_q;
  assign dbg_state_o = state_q;

endmodule
